// File: rtl/modulo_updown_counter_if.sv
// Control/status bundle for modulo_updown_counter; the prescale tick exists only
// when COUNTER_PRESCALE_EN is defined.
interface modulo_updown_counter_if #(
    parameter int N = 64
);
    logic         enable;
    logic         load;
    logic         direction;
    logic         saturate;
    logic [N-1:0] data_in;
    logic [N-1:0] step;
    logic [N-1:0] count;
    logic         terminal_count;
    logic         wrap_pulse;
    logic         overflow;
`ifdef COUNTER_PRESCALE_EN
    logic         prescale_tick;

    modport master (
        output enable, load, direction, saturate, data_in, step,
        input  count, terminal_count, wrap_pulse, overflow, prescale_tick
    );

    modport slave (
        input  enable, load, direction, saturate, data_in, step,
        output count, terminal_count, wrap_pulse, overflow, prescale_tick
    );
`else
    modport master (
        output enable, load, direction, saturate, data_in, step,
        input  count, terminal_count, wrap_pulse, overflow
    );

    modport slave (
        input  enable, load, direction, saturate, data_in, step,
        output count, terminal_count, wrap_pulse, overflow
    );
`endif
endinterface

// File: rtl/modulo_updown_counter.sv
// Up/down counter over 0..MAX with wrap or saturate, boundary pulse and sticky overflow.
// Optional COUNTER_PRESCALE_EN: a step is taken only every PRESCALE-th enabled cycle.
module modulo_updown_counter #(
    parameter int           N           = 64,
    parameter logic [N-1:0] MAX         = {N{1'b1}},
    parameter logic [N-1:0] RESET_VALUE = '0
`ifdef COUNTER_PRESCALE_EN
    ,
    parameter int           PRESCALE    = 4
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    modulo_updown_counter_if.slave  bus
);

    // One extra bit so Count+Step and Count+MAX+1 never truncate.
    localparam logic [N:0] MAX_EXT   = {1'b0, MAX};
    localparam logic [N:0] RANGE_EXT = MAX_EXT + 1'b1;

    logic [N-1:0] count_q, count_d;
    logic         wrap_q, wrap_d;
    logic         ovf_q, ovf_d;
    logic         step_en;
    logic         crossing;
    logic [N:0]   cnt_ext, step_ext, sum_ext, next_ext;

`ifdef COUNTER_PRESCALE_EN
    localparam int           PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    assign tick              = bus.enable && !bus.load && (pre_q == PRE_LAST);
    assign step_en           = tick;
    assign bus.prescale_tick = tick;

    always_comb begin
        pre_d = pre_q;
        if (bus.load)        pre_d = '0;
        else if (bus.enable) pre_d = tick ? '0 : pre_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
    end
`else
    assign step_en = bus.enable && !bus.load;
`endif

    always_comb begin
        cnt_ext  = {1'b0, count_q};
        step_ext = {1'b0, bus.step};
        sum_ext  = cnt_ext + step_ext;
        if (bus.direction) begin
            crossing = (sum_ext > MAX_EXT);
            next_ext = crossing ? (bus.saturate ? MAX_EXT : sum_ext - RANGE_EXT) : sum_ext;
        end else begin
            crossing = (step_ext > cnt_ext);
            next_ext = crossing ? (bus.saturate ? '0 : cnt_ext + RANGE_EXT - step_ext)
                                : cnt_ext - step_ext;
        end
    end

    // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (bus.load) begin
            count_d = (bus.data_in > MAX) ? MAX : bus.data_in;
            ovf_d   = 1'b0;
        end else if (step_en) begin
            count_d = next_ext[N-1:0];
            wrap_d  = crossing;
            ovf_d   = ovf_q | crossing;
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RESET_VALUE;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count          = count_q;
    assign bus.wrap_pulse     = wrap_q;
    assign bus.overflow       = ovf_q;
    assign bus.terminal_count = bus.direction ? (count_q == MAX) : (count_q == '0);

    step_le_max: assert property (@(posedge clk) disable iff (!rst_n) bus.step <= MAX);

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized traffic against an integer reference model.
module tb_modulo_updown_counter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    modulo_updown_counter_if #(.N(8))  if8 ();
    modulo_updown_counter_if #(.N(64)) if64 ();

    modulo_updown_counter #(
        .N(8), .MAX(8'd9), .RESET_VALUE(8'd3)
`ifdef COUNTER_PRESCALE_EN
        , .PRESCALE(1)
`endif
    ) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    modulo_updown_counter #(
        .N(64)
`ifdef COUNTER_PRESCALE_EN
        , .PRESCALE(1)
`endif
    ) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

`ifdef COUNTER_PRESCALE_EN
    modulo_updown_counter_if #(.N(8)) ifp ();
    modulo_updown_counter #(
        .N(8), .MAX(8'd9), .RESET_VALUE(8'd0), .PRESCALE(4)
    ) dutp (.clk(clk), .rst_n(rst_n), .bus(ifp));
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive8(input logic ld, input logic en, input logic dir, input logic sat,
                          input logic [7:0] din, input logic [7:0] stp);
        if8.load      = ld;
        if8.enable    = en;
        if8.direction = dir;
        if8.saturate  = sat;
        if8.data_in   = din;
        if8.step      = stp;
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic       load, en, dir, sat;
        logic [7:0] din, step;
        logic [7:0] cnt;
        logic       tc, wp, ov;
    } vec_t;

    vec_t tbl[14];

    // Reference model for MAX=9: plain integer arithmetic on the range 0..9.
    int m_cnt, m_wp, m_ov;
    task automatic model(input int ld, input int en, input int dir, input int sat,
                         input int din, input int stp);
        m_wp = 0;
        if (ld != 0) begin
            m_cnt = (din > 9) ? 9 : din;
            m_ov  = 0;
        end else if (en != 0) begin
            if (dir != 0) begin
                if (m_cnt + stp > 9) begin
                    m_wp  = 1;
                    m_cnt = (sat != 0) ? 9 : (m_cnt + stp) % 10;
                end else m_cnt = m_cnt + stp;
            end else begin
                if (stp > m_cnt) begin
                    m_wp  = 1;
                    m_cnt = (sat != 0) ? 0 : (m_cnt - stp + 10) % 10;
                end else m_cnt = m_cnt - stp;
            end
            if (m_wp != 0) m_ov = 1;
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd7,   8'd0, 8'd7, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   8'd2, 8'd9, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   8'd2, 8'd1, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd2, 8'd1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd2,   8'd0, 8'd2, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0,   8'd3, 8'd0, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0,   8'd3, 8'd0, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd5,   8'd0, 8'd5, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd200, 8'd3, 8'd9, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   8'd0, 8'd9, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   8'd1, 8'd9, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   8'd4, 8'd5, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   8'd7, 8'd8, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 8'd8, 1'b0, 1'b0, 1'b1};

        drive8(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        if64.load = 1'b0; if64.enable = 1'b0; if64.direction = 1'b1;
        if64.saturate = 1'b0; if64.data_in = '0; if64.step = '0;
`ifdef COUNTER_PRESCALE_EN
        ifp.load = 1'b0; ifp.enable = 1'b0; ifp.direction = 1'b1;
        ifp.saturate = 1'b0; ifp.data_in = '0; ifp.step = '0;
`endif

        // Power-on reset.
        #1 rst_n = 1'b0;
        #2;
        check("reset_count", 64'(if8.count), 64'd3);
        check("reset_wrap", 64'(if8.wrap_pulse), 64'd0);
        check("reset_ovf", 64'(if8.overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            drive8(tbl[i].load, tbl[i].en, tbl[i].dir, tbl[i].sat, tbl[i].din, tbl[i].step);
            tick_clk();
            check($sformatf("tbl%0d_count", i), 64'(if8.count), 64'(tbl[i].cnt));
            check($sformatf("tbl%0d_tc", i), 64'(if8.terminal_count), 64'(tbl[i].tc));
            check($sformatf("tbl%0d_wrap", i), 64'(if8.wrap_pulse), 64'(tbl[i].wp));
            check($sformatf("tbl%0d_ovf", i), 64'(if8.overflow), 64'(tbl[i].ov));
        end

        // Mid-cycle reset clears a pending wrap pulse and overflow immediately.
        drive8(1'b1, 1'b0, 1'b1, 1'b0, 8'd8, 8'd0);
        tick_clk();
        drive8(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd6);
        tick_clk();
        check("prerst_count", 64'(if8.count), 64'd4);
        check("prerst_wrap", 64'(if8.wrap_pulse), 64'd1);
        drive8(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_count", 64'(if8.count), 64'd3);
        check("midrst_wrap", 64'(if8.wrap_pulse), 64'd0);
        check("midrst_ovf", 64'(if8.overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        m_cnt = 3; m_wp = 0; m_ov = 0;
        for (int i = 0; i < 400; i++) begin
            logic ld, en, dir, sat;
            logic [7:0] din, stp;
            ld  = (i == 0) || ($urandom_range(0, 9) == 0);
            en  = ($urandom_range(0, 3) != 0);
            dir = 1'($urandom);
            sat = 1'($urandom);
            din = 8'($urandom);
            stp = 8'($urandom_range(0, 9));
            drive8(ld, en, dir, sat, din, stp);
            model(int'(ld), int'(en), int'(dir), int'(sat), int'(din), int'(stp));
            tick_clk();
            check("rnd_count", 64'(if8.count), 64'(m_cnt));
            check("rnd_tc", 64'(if8.terminal_count), (dir ? (m_cnt == 9) : (m_cnt == 0)) ? 64'd1 : 64'd0);
            check("rnd_wrap", 64'(if8.wrap_pulse), 64'(m_wp));
            check("rnd_ovf", 64'(if8.overflow), 64'(m_ov));
        end
        drive8(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);

        // Full-width wrap and saturate at 2**64-1.
        if64.load = 1'b1; if64.data_in = 64'hFFFF_FFFF_FFFF_FFFE;
        tick_clk();
        check("w64_load", if64.count, 64'hFFFF_FFFF_FFFF_FFFE);
        if64.load = 1'b0; if64.enable = 1'b1; if64.step = 64'd3;
        tick_clk();
        check("w64_wrap_count", if64.count, 64'd1);
        check("w64_wrap_pulse", 64'(if64.wrap_pulse), 64'd1);
        check("w64_ovf", 64'(if64.overflow), 64'd1);
        if64.load = 1'b1; if64.enable = 1'b0; if64.data_in = 64'hFFFF_FFFF_FFFF_FFFE;
        tick_clk();
        if64.load = 1'b0; if64.enable = 1'b1; if64.saturate = 1'b1;
        tick_clk();
        check("w64_sat_count", if64.count, 64'hFFFF_FFFF_FFFF_FFFF);
        check("w64_sat_tc", 64'(if64.terminal_count), 64'd1);
        check("w64_sat_pulse", 64'(if64.wrap_pulse), 64'd1);
        if64.enable = 1'b0;

`ifdef COUNTER_PRESCALE_EN
        ifp.load = 1'b1; ifp.data_in = 8'd0;
        tick_clk();
        ifp.load = 1'b0; ifp.enable = 1'b1; ifp.step = 8'd1;
        for (int k = 1; k <= 8; k++) begin
            #1;
            check($sformatf("pre_tick%0d", k), 64'(ifp.prescale_tick), (k % 4 == 0) ? 64'd1 : 64'd0);
            tick_clk();
        end
        check("pre_count", 64'(ifp.count), 64'd2);
        ifp.enable = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
